// File: rtl/sdf_r2_bf4.sv
// ---------------------------------------------------------------------------
// sdf_r2_bf4 : radix-2 DIF single-path delay-feedback butterfly stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sdf_r2_bf4 #(
  parameter int WIDTH = 24,
  parameter int DELAY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din_r,
  input  logic [WIDTH-1:0] din_i,
  input  logic [WIDTH-1:0] dly_r,
  input  logic [WIDTH-1:0] dly_i,
  output logic             dly_en,
  output logic [WIDTH-1:0] to_dly_r,
  output logic [WIDTH-1:0] to_dly_i,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout_r,
  output logic [WIDTH-1:0] dout_i
);

  localparam int CW = $clog2(2*DELAY);
  localparam logic [CW-1:0] C_LAST = CW'(DELAY-1);
  localparam logic [CW-1:0] C_HALF = CW'(DELAY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] dout_r_q;
  logic [WIDTH-1:0] dout_i_q;

  logic             w_accept;
  logic             w_phase_b;
  logic [WIDTH-1:0] w_din_r;
  logic [WIDTH-1:0] w_din_i;
  logic [WIDTH:0]   w_sum_r;
  logic [WIDTH:0]   w_sum_i;
  logic [WIDTH:0]   w_diff_r;
  logic [WIDTH:0]   w_diff_i;

  assign in_ready  = (state_q != S_DRAIN);
  assign w_accept  = in_valid && in_ready;
  assign w_phase_b = (cnt_q >= C_HALF);

  // Draining pushes zeros so the stored differences fall straight out.
  assign w_din_r = (state_q == S_DRAIN) ? '0 : din_r;
  assign w_din_i = (state_q == S_DRAIN) ? '0 : din_i;

  // One guard bit, then bits [WIDTH:1] give the floor of the halved result.
  assign w_sum_r  = {dly_r[WIDTH-1], dly_r} + {w_din_r[WIDTH-1], w_din_r};
  assign w_sum_i  = {dly_i[WIDTH-1], dly_i} + {w_din_i[WIDTH-1], w_din_i};
  assign w_diff_r = {dly_r[WIDTH-1], dly_r} - {w_din_r[WIDTH-1], w_din_r};
  assign w_diff_i = {dly_i[WIDTH-1], dly_i} - {w_din_i[WIDTH-1], w_din_i};

  assign to_dly_r = w_phase_b ? w_diff_r[WIDTH:1] : w_din_r;
  assign to_dly_i = w_phase_b ? w_diff_i[WIDTH:1] : w_din_i;
  assign dly_en   = !rst && (w_accept || (state_q == S_DRAIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            cnt_q   <= CW'(1);
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == C_LAST) state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            cnt_q       <= cnt_q + CW'(1);
            out_valid_q <= 1'b1;
            if (w_phase_b) begin
              dout_r_q <= w_sum_r[WIDTH:1];
              dout_i_q <= w_sum_i[WIDTH:1];
            end else begin
              dout_r_q <= dly_r;
              dout_i_q <= dly_i;
            end
          end else if (cnt_q == '0) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          out_valid_q <= 1'b1;
          dout_r_q    <= dly_r;
          dout_i_q    <= dly_i;
          if (cnt_q == C_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;

endmodule

`default_nettype wire

// File: tb/tb_sdf_r2_bf4.sv
// ---------------------------------------------------------------------------
// tb_sdf_r2_bf4 : directed bench for sdf_r2_bf4 with a behavioural delay line
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sdf_r2_bf4;

  localparam int W    = 24;
  localparam int D    = 4;
  localparam int C_MAX = 8388607;
  localparam int C_MIN = -8388608;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din_r;
  logic [W-1:0] din_i;
  logic [W-1:0] dly_r;
  logic [W-1:0] dly_i;
  logic         dly_en;
  logic [W-1:0] to_dly_r;
  logic [W-1:0] to_dly_i;
  logic         out_valid;
  logic [W-1:0] dout_r;
  logic [W-1:0] dout_i;

  always #5 clk = ~clk;

  sdf_r2_bf4 #(.WIDTH(W), .DELAY(D)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din_r    (din_r),
    .din_i    (din_i),
    .dly_r    (dly_r),
    .dly_i    (dly_i),
    .dly_en   (dly_en),
    .to_dly_r (to_dly_r),
    .to_dly_i (to_dly_i),
    .out_valid(out_valid),
    .dout_r   (dout_r),
    .dout_i   (dout_i)
  );

  // External feedback delay line, never reset.
  logic [W-1:0] sr_r [D] = '{default: '0};
  logic [W-1:0] sr_i [D] = '{default: '0};
  always @(posedge clk) begin
    if (dly_en) begin
      for (int k = D-1; k > 0; k--) begin
        sr_r[k] <= sr_r[k-1];
        sr_i[k] <= sr_i[k-1];
      end
      sr_r[0] <= to_dly_r;
      sr_i[0] <= to_dly_i;
    end
  end
  assign dly_r = sr_r[D-1];
  assign dly_i = sr_i[D-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_r[$];
  int q_i[$];
  int q_c[$];
  int ready_low = 0;
  always @(negedge clk) begin
    if (out_valid) begin
      q_r.push_back($signed(dout_r));
      q_i.push_back($signed(dout_i));
      q_c.push_back(cyc);
    end
    if (!in_ready) ready_low = ready_low + 1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int r, input int i);
    in_valid = 1'b1;
    din_r    = W'(r);
    din_i    = W'(i);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    din_r    = '0;
    din_i    = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_block(input string tag, input int base, input int t0,
                             input int er[$], input int ei[$]);
    check_val({tag, "_count"}, q_r.size() - base, er.size());
    if (q_c.size() > base)
      check_val({tag, "_latency"}, q_c[base] - t0, D + 1);
    for (int k = 0; k < er.size(); k++) begin
      if (base + k < q_r.size()) begin
        check_val($sformatf("%s_r%0d", tag, k), q_r[base+k], er[k]);
        check_val($sformatf("%s_i%0d", tag, k), q_i[base+k], ei[k]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t0, rl0;
    int er[$];
    int ei[$];

    // Reset with input active: nothing may be accepted or produced.
    rst = 1'b1; in_valid = 1'b1; din_r = W'(5); din_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_dout_r", $signed(dout_r), 0);
    check_val("rst_dout_i", $signed(dout_i), 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_dly_en", dly_en, 0);
    rst = 1'b0;
    idle(2);

    // Single block 1..8.
    base = q_r.size(); rl0 = ready_low; t0 = cyc;
    for (int k = 1; k <= 8; k++) send(k, 0);
    idle(12);
    er = '{3, 4, 5, 6, -2, -2, -2, -2};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_block("single", base, t0, er, ei);
    check_val("single_drain_ready_low", ready_low - rl0, D);
    check_val("single_ready_after", in_ready, 1);

    // Back-to-back blocks.
    base = q_r.size(); t0 = cyc;
    for (int k = 1; k <= 8; k++) send(k, 0);
    for (int k = 1; k <= 8; k++) send(10*k, 0);
    idle(12);
    er = '{3, 4, 5, 6, -2, -2, -2, -2, 30, 40, 50, 60, -20, -20, -20, -20};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_block("b2b", base, t0, er, ei);

    // Mid-block stall after sample 6.
    base = q_r.size(); t0 = cyc;
    for (int k = 1; k <= 6; k++) send(k, 0);
    in_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      check_val($sformatf("stall_dly_en%0d", g), dly_en, 0);
      @(posedge clk);
      #1;
      check_val($sformatf("stall_out_valid%0d", g), out_valid, 0);
    end
    send(7, 0);
    send(8, 0);
    idle(12);
    er = '{3, 4, 5, 6, -2, -2, -2, -2};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_block("stall", base, t0, er, ei);

    // Full-scale operands and floor rounding of negative odd results.
    base = q_r.size(); t0 = cyc;
    send(C_MAX, 0); send(C_MIN, 0); send(0, 3);  send(0, 0);
    send(C_MAX, 0); send(C_MAX, 0); send(0, -4); send(0, 0);
    idle(12);
    er = '{C_MAX, -1, 0, 0, 0, C_MIN, 0, 0};
    ei = '{0, 0, -1, 0, 0, 0, 3, 0};
    check_block("extreme", base, t0, er, ei);

    // Reset in the middle of a running block.
    for (int k = 1; k <= 5; k++) send(k, 0);
    rst = 1'b1; in_valid = 1'b1; din_r = W'(6); din_i = '0;
    @(posedge clk);
    #1;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_dout_r", $signed(dout_r), 0);
    check_val("midrst_in_ready", in_ready, 1);
    rst = 1'b0;
    idle(2);
    base = q_r.size(); t0 = cyc;
    for (int k = 1; k <= 8; k++) send(k, 2*k);
    idle(12);
    er = '{3, 4, 5, 6, -2, -2, -2, -2};
    ei = '{6, 8, 10, 12, -4, -4, -4, -4};
    check_block("fresh", base, t0, er, ei);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sdf_r2_bf4.md
Name: sdf_r2_bf4

Overview:
- Radix-2 DIF single-path delay-feedback (SDF) butterfly stage for the OFDM FFT datapath.
- Pairs with an external DELAY-deep complex feedback delay line (shift_4 when DELAY=4), which sits beside it:
  - this block drives the delay line's input and shift enable;
  - it consumes the delay line's output.
- Output is the natural-order-per-block DIF butterfly result: sums first, then differences. It goes to the next twiddle/stage.

Parameters:
- WIDTH, 24, signed bit width of each real/imag component (data, delay line and outputs).
- DELAY, 4, feedback delay depth; power of two ≥2; block length is 2*DELAY.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid; accepted only when in_ready=1.
- in_ready  out  1  block can accept input.
- din_r  in  WIDTH  input sample, real, signed.
- din_i  in  WIDTH  input sample, imag, signed.
- dly_r  in  WIDTH  delay line output, real (sample from DELAY shifts ago).
- dly_i  in  WIDTH  delay line output, imag.
- dly_en  out  1  delay line shift enable (drives its in_valid).
- to_dly_r  out  WIDTH  delay line input, real.
- to_dly_i  out  WIDTH  delay line input, imag.
- out_valid  out  1  dout valid.
- dout_r  out  WIDTH  stage output, real.
- dout_i  out  WIDTH  stage output, imag.

Behaviour:
- Reset:
  - state=IDLE, cnt=0, out_valid=0, dout_r=dout_i=0, in_ready=1.
  - Reset mid-operation discards the block in progress; the delay line contents are don't-care after reset.
- State machine:
  - IDLE: accepted sample -> FILL with cnt=1.
  - FILL: after DELAY accepted samples in total -> RUN.
  - RUN, idle input with cnt==0 (block boundary) -> DRAIN.
  - RUN, idle input with cnt!=0 -> stall: cnt held, dly_en=0, out_valid=0, state unchanged.
  - DRAIN: lasts exactly DELAY cycles, then -> IDLE.
  - in_ready=0 only in DRAIN.
- Counter:
  - cnt is log2(2*DELAY) bits and increments on every accepted or drain cycle, wrapping at 2*DELAY.
  - Phase A = cnt < DELAY; phase B = cnt ≥ DELAY.
- Phase A, accepted sample:
  - to_dly = din; dly_en = 1.
  - In RUN, dout <= dly (stored scaled difference), out_valid <= 1.
  - In FILL, out_valid <= 0.
- Phase B, accepted sample:
  - Sum s = (dly + din) computed in WIDTH+1 bits, arithmetic shift right 1 (floor); dout <= s; out_valid <= 1.
  - Difference d = (dly - din), same width rule and shift; to_dly = d; dly_en = 1.
- DRAIN cycle:
  - din is treated as 0 and dly_en = 1.
  - dout <= dly, out_valid <= 1. This flushes the last block's differences.
- Timing of combinational vs registered outputs:
  - to_dly and dly_en are combinational from state, cnt, in_valid, din and dly, so the delay is exactly DELAY shifts.
  - dout and out_valid are registered.
- Latency: the first output appears DELAY+1 cycles after the first accepted sample.
- Cycles with no output: out_valid=0 and dout holds its last value.
- Scaling: the 1/2 per stage prevents overflow. No saturation is needed; the floor bias is accepted.
- Protocol:
  - Input streams end on a block boundary (multiple of 2*DELAY samples).
  - in_valid while in_ready=0 is ignored (not accepted, no state effect).

Test Plan:
- Reset then IDLE, DELAY=4:
  - Hold rst 2 cycles with in_valid=1 -> out_valid=0, dout=0, in_ready=1, dly_en=0.
- Single block:
  - Input 1..8 (imag 0) on consecutive cycles.
  - out_valid rises 5 cycles after the first sample.
  - dout_r sequence: 3,4,5,6 (sums/2), then -2,-2,-2,-2 (diffs/2 during DRAIN).
  - in_ready=0 for those 4 drain cycles, then 1.
- Back-to-back blocks:
  - Input 1..8, then 10,20,...,80 with no gap.
  - First block's differences (-2 ×4) come out in RUN phase A of block 2.
  - Then 30,40,50,60, then -20 ×4 in DRAIN.
  - out_valid continuous for 16 cycles.
- Mid-block stall:
  - Drop in_valid for 3 cycles after sample 6 of 1..8.
  - cnt held, dly_en=0, out_valid=0 during the gap.
  - Resume -> outputs identical to the single-block case, shifted by 3 cycles.
- Rounding/extremes:
  - Inputs give dly=8388607 with din=8388607 -> dout=8388607.
  - dly=-8388608 with din=8388607 -> sum -1>>1 = -1; diff = -16777215>>1 = -8388608; no wrap.
- Reset mid-RUN:
  - Assert rst at cycle 6 -> next cycle out_valid=0, state IDLE, dout=0.
  - A fresh block afterwards -> correct outputs.
